// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - SHA-256 compression engine, one round per clock.
module sha256_compress #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [16*DATA_WIDTH-1:0] block_in,
  input  logic [8*DATA_WIDTH-1:0]  hash_in,
  output logic                    busy,
  output logic                    done,
  output logic [8*DATA_WIDTH-1:0]  hash_out
);
  localparam int W = DATA_WIDTH;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] big_sigma0(input logic [W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [W-1:0] big_sigma1(input logic [W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [W-1:0] small_sigma0(input logic [W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [W-1:0] small_sigma1(input logic [W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t         state;
  logic [5:0]     t;
  logic [W-1:0]   wk [8];   // working variables a..h
  logic [W-1:0]   hs [8];   // chaining value saved for the feed-forward add
  logic [W-1:0]   w  [16];  // sliding message-schedule window, w[0] = Wt
  logic [W-1:0]   t1, t2, w_next;

  always_comb begin
    t1 = '0;
    t2 = '0;
    w_next = '0;
    t1 = wk[7] + big_sigma1(wk[4]) + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[t] + w[0];
    t2 = big_sigma0(wk[0]) + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
    w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hash_out <= '0;
      for (int i = 0; i < 8; i++) begin
        wk[i] <= '0;
        hs[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              wk[i] <= hash_in[(7-i)*W +: W];
              hs[i] <= hash_in[(7-i)*W +: W];
            end
            for (int i = 0; i < 16; i++) w[i] <= block_in[(15-i)*W +: W];
            t     <= '0;
            busy  <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          wk[7] <= wk[6];
          wk[6] <= wk[5];
          wk[5] <= wk[4];
          wk[4] <= wk[3] + t1;
          wk[3] <= wk[2];
          wk[2] <= wk[1];
          wk[1] <= wk[0];
          wk[0] <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next;
          if (t == 6'd63) begin
            state <= FINAL;
          end else begin
            t <= t + 6'd1;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hash_out[(7-i)*W +: W] <= hs[i] + wk[i];
          done  <= 1'b1;
          busy  <= 1'b0;
          t     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - directed-vector bench for sha256_compress.
module tb_sha256_compress;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {{15{32'h0}}, 32'h000001c0};

  typedef struct {
    logic [511:0] blk;
    logic [255:0] hin;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [2];

  sha256_compress #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge after an accept edge; returns at the negedge where done is seen.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_block(input logic [511:0] blk, input logic [255:0] hin,
                           output int lat, output logic busy_ok);
    @(negedge clk);
    block_in = blk;
    hash_in  = hin;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_ok);
  endtask

  initial begin
    int   lat, lat2, pulses;
    logic bok;

    vecs[0] = '{blk: B_ABC,   hin: IV, exp: D_ABC};
    vecs[1] = '{blk: B_EMPTY, hin: IV, exp: D_EMPTY};

    rst = 1'b1;
    start = 1'b0;
    block_in = '0;
    hash_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_done", 256'(done), 256'(0));
    check("reset_hash_out", hash_out, 256'h0);
    rst = 1'b0;

    for (int v = 0; v < 2; v++) begin
      run_block(vecs[v].blk, vecs[v].hin, lat, bok);
      check($sformatf("vec%0d_latency", v), 256'(lat), 256'(65));
      check($sformatf("vec%0d_busy_during", v), 256'(bok), 256'(1));
      check($sformatf("vec%0d_busy_at_done", v), 256'(busy), 256'(0));
      check($sformatf("vec%0d_digest", v), hash_out, vecs[v].exp);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", v), 256'(done), 256'(0));
      check($sformatf("vec%0d_hash_held", v), hash_out, vecs[v].exp);
    end

    // Two-block chain, second block started in the done cycle of the first.
    run_block(B_TWO1, IV, lat, bok);
    check("two_lat1", 256'(lat), 256'(65));
    block_in = B_TWO2;
    hash_in  = hash_out;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("two_busy_after_back_to_back", 256'(busy), 256'(1));
    wait_done(lat2, bok);
    check("two_lat2", 256'(lat2), 256'(65));
    check("two_digest", hash_out, D_TWO);

    // start held high, inputs scrambled during the rounds.
    @(negedge clk);
    block_in = B_ABC;
    hash_in  = IV;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!done && lat < 200) begin
      for (int i = 0; i < 16; i++) block_in[i*32 +: 32] = $urandom;
      for (int i = 0; i < 8; i++) hash_in[i*32 +: 32] = $urandom;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check("held_latency", 256'(lat), 256'(65));
    check("held_digest", hash_out, D_ABC);
    pulses = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("held_extra_done", 256'(pulses), 256'(0));

    // Reset at round t=30 (edge E31) discards the run.
    @(negedge clk);
    block_in = B_ABC;
    hash_in  = IV;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_hash_out", hash_out, 256'h0);
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_no_done", 256'(pulses), 256'(0));
    run_block(B_ABC, IV, lat, bok);
    check("post_rst_latency", 256'(lat), 256'(65));
    check("post_rst_digest", hash_out, D_ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
